// File: rtl/ysyx_041461_pipe_ctrl.sv
// ysyx_041461_pipe_ctrl: central hazard / flow-control unit.
// Drives the load/flush controls of the PC and the IF->ID, ID->EXE,
// EXE->MEM and MEM->WB pipeline registers. A small FSM tracks
// wrong-path fetches (DROP) and trap drains (TRAP_WAIT).
// Optional feature macro: YSYX_041461_PIPE_PERF_EN builds the saturating
// load-use / redirect performance counters; otherwise both ports read 0.
module ysyx_041461_pipe_ctrl #(
  parameter int RF_AW = 5,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ID_valid,
  input  logic [RF_AW-1:0] ID_rs1,
  input  logic [RF_AW-1:0] ID_rs2,
  input  logic             ID_rs1_used,
  input  logic             ID_rs2_used,
  input  logic             EXE_valid,
  input  logic [RF_AW-1:0] EXE_rd,
  input  logic             EXE_is_load,
  input  logic             EXE_busy,
  input  logic             EXE_redirect,
  input  logic             MEM_busy,
  input  logic             IF_busy,
  input  logic             WB_trap,
  output logic             PC_enable,
  output logic             IDreg_enable,
  output logic             EXEreg_enable,
  output logic             MEMreg_enable,
  output logic             WBreg_enable,
  output logic             IDreg_flush,
  output logic             EXEreg_flush,
  output logic             MEMreg_flush,
  output logic             WBreg_flush,
  output logic [1:0]       redirect_sel,
  output logic [CNT_W-1:0] loaduse_cnt,
  output logic [CNT_W-1:0] redirect_cnt
);

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_DROP      = 2'd1,
    ST_TRAP_WAIT = 2'd2
  } state_t;

  localparam logic [1:0] SEL_SEQ  = 2'b00;
  localparam logic [1:0] SEL_EXE  = 2'b01;
  localparam logic [1:0] SEL_TRAP = 2'b10;

  state_t state_r;
  state_t state_nxt_s;
  logic   load_use_s;
  logic   loaduse_bubble_s;
  logic   redirect_acc_s;

  // Raw load-use condition: a valid ID source depends on an in-flight load.
  always_comb begin
    load_use_s = ID_valid && EXE_valid && EXE_is_load && (EXE_rd != {RF_AW{1'b0}}) &&
                 ((ID_rs1_used && (ID_rs1 == EXE_rd)) || (ID_rs2_used && (ID_rs2 == EXE_rd)));
  end

  // Control decode: priority chain per state; every branch sets all registers.
  always_comb begin
    PC_enable        = 1'b1;
    IDreg_enable     = 1'b1;
    EXEreg_enable    = 1'b1;
    MEMreg_enable    = 1'b1;
    WBreg_enable     = 1'b1;
    IDreg_flush      = 1'b0;
    EXEreg_flush     = 1'b0;
    MEMreg_flush     = 1'b0;
    WBreg_flush      = 1'b0;
    redirect_sel     = SEL_SEQ;
    state_nxt_s      = state_r;
    loaduse_bubble_s = 1'b0;
    redirect_acc_s   = 1'b0;
    if (!rst_n) begin
      PC_enable     = 1'b0;
      IDreg_enable  = 1'b0;
      EXEreg_enable = 1'b0;
      MEMreg_enable = 1'b0;
      WBreg_enable  = 1'b0;
      state_nxt_s   = ST_RUN;
    end else begin
      case (state_r)
        ST_TRAP_WAIT: begin
          if (!MEM_busy && !IF_busy) begin
            // Drain complete: jump to the trap vector and squash everything.
            IDreg_flush  = 1'b1;
            EXEreg_flush = 1'b1;
            MEMreg_flush = 1'b1;
            WBreg_flush  = 1'b1;
            redirect_sel = SEL_TRAP;
            state_nxt_s  = ST_RUN;
          end else begin
            PC_enable     = 1'b0;
            IDreg_enable  = 1'b0;
            EXEreg_enable = 1'b0;
            MEMreg_enable = 1'b0;
            WBreg_flush   = 1'b1;
          end
        end
        ST_RUN, ST_DROP: begin
          if (WB_trap && (MEM_busy || IF_busy || (state_r == ST_DROP))) begin
            // Trap cannot redirect yet: freeze front end, drain into WB bubbles.
            PC_enable     = 1'b0;
            IDreg_enable  = 1'b0;
            EXEreg_enable = 1'b0;
            MEMreg_enable = 1'b0;
            WBreg_flush   = 1'b1;
            state_nxt_s   = ST_TRAP_WAIT;
          end else if (WB_trap) begin
            // Immediate trap; any same-cycle EXE redirect is discarded.
            IDreg_flush  = 1'b1;
            EXEreg_flush = 1'b1;
            MEMreg_flush = 1'b1;
            WBreg_flush  = 1'b1;
            redirect_sel = SEL_TRAP;
            state_nxt_s  = ST_RUN;
          end else if (MEM_busy) begin
            PC_enable     = 1'b0;
            IDreg_enable  = 1'b0;
            EXEreg_enable = 1'b0;
            MEMreg_enable = 1'b0;
            WBreg_flush   = 1'b1;
          end else if (EXE_busy) begin
            PC_enable     = 1'b0;
            IDreg_enable  = 1'b0;
            EXEreg_enable = 1'b0;
            MEMreg_flush  = 1'b1;
          end else if (EXE_redirect) begin
            IDreg_flush    = 1'b1;
            EXEreg_flush   = 1'b1;
            redirect_sel   = SEL_EXE;
            redirect_acc_s = 1'b1;
            state_nxt_s    = IF_busy ? ST_DROP : ST_RUN;
          end else if (load_use_s) begin
            // ID held, so a pending wrong-path discard stays pending in DROP.
            PC_enable        = 1'b0;
            IDreg_enable     = 1'b0;
            EXEreg_flush     = 1'b1;
            loaduse_bubble_s = 1'b1;
          end else if (IF_busy) begin
            PC_enable   = 1'b0;
            IDreg_flush = 1'b1;
          end else if (state_r == ST_DROP) begin
            // Wrong-path fetch returned this cycle: discard it.
            IDreg_flush = 1'b1;
            state_nxt_s = ST_RUN;
          end else begin
            state_nxt_s = ST_RUN;
          end
        end
        default: begin
          state_nxt_s = ST_RUN;
        end
      endcase
    end
  end

  // FSM state register; reset drops any pending DROP/TRAP_WAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_RUN;
    end else begin
      state_r <= state_nxt_s;
    end
  end

`ifdef YSYX_041461_PIPE_PERF_EN
  logic [CNT_W-1:0] loaduse_cnt_r;
  logic [CNT_W-1:0] redirect_cnt_r;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) begin
      sat_inc = v;
    end else begin
      sat_inc = v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

  // Saturating event counters for load-use bubbles and accepted redirects.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      loaduse_cnt_r  <= {CNT_W{1'b0}};
      redirect_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if (loaduse_bubble_s) begin
        loaduse_cnt_r <= sat_inc(loaduse_cnt_r);
      end
      if (redirect_acc_s) begin
        redirect_cnt_r <= sat_inc(redirect_cnt_r);
      end
    end
  end

  assign loaduse_cnt  = loaduse_cnt_r;
  assign redirect_cnt = redirect_cnt_r;
`else
  logic unused_perf_s;
  assign unused_perf_s = loaduse_bubble_s ^ redirect_acc_s;
  assign loaduse_cnt   = {CNT_W{1'b0}};
  assign redirect_cnt  = {CNT_W{1'b0}};
`endif

endmodule

// File: doc/ysyx_041461_pipe_ctrl.md
Name: ysyx_041461_pipe_ctrl

Overview:
Central hazard and flow-control unit that drives the enable and flush inputs of every inter-stage pipeline register (IF→ID, ID→EXE, EXE→MEM, MEM→WB) and the PC register.
- Resolves load-use hazards, multicycle EXE stalls, memory and fetch wait states, EXE branch redirects and WB-committed traps.
- Tracks wrong-path fetches and trap drains with a small FSM.

Parameters:
RF_AW, 5, register-file index width.
CNT_W, 32, width of the performance counters.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
ID_valid  in  1  ID stage holds a valid instruction
ID_rs1 / ID_rs2  in  RF_AW  ID source register indices
ID_rs1_used / ID_rs2_used  in  1  source actually read
EXE_valid  in  1  EXE holds a valid instruction
EXE_rd  in  RF_AW  EXE destination index
EXE_is_load  in  1  EXE instruction is a load
EXE_busy  in  1  multicycle unit (mul/div) not done
EXE_redirect  in  1  EXE resolved a taken branch or jump
MEM_busy  in  1  data access outstanding
IF_busy  in  1  instruction fetch outstanding
WB_trap  in  1  one-cycle pulse: trap/ecall/mret committed in WB
PC_enable  out  1  PC register load
IDreg_enable / EXEreg_enable / MEMreg_enable / WBreg_enable  out  1 each  1 = load, 0 = hold
IDreg_flush / EXEreg_flush / MEMreg_flush / WBreg_flush  out  1 each  load a bubble (valid=0) on the next edge
redirect_sel  out  2  PC source: 00 sequential, 01 EXE target, 10 trap vector from CSR
loaduse_cnt / redirect_cnt  out  CNT_W each  performance counters

Behaviour:
- Outputs are combinational from FSM state and inputs.
- While rst_n=0:
  - all enables 0, all flushes 0, redirect_sel=00;
  - state←RUN; counters←0.
- A flush is only meaningful with its enable=1. The controller always asserts the enable together with the flush.
- Default in RUN with no hazard: all enables 1, flushes 0, redirect_sel=00.
- Hazard priority, highest first. Each rule overrides lower-priority ones for the registers it touches.
  1. MEM_busy:
     - PC, ID, EXE, MEM regs hold.
     - WB reg loads a bubble.
  2. EXE_busy:
     - PC, ID, EXE hold.
     - MEM loads a bubble.
  3. EXE_redirect (only when not MEM_busy/EXE_busy):
     - PC_enable=1, redirect_sel=01.
     - IDreg_flush=1, EXEreg_flush=1.
     - If IF_busy=1 in the same cycle: next state DROP.
  4. Load-use: ID_valid & EXE_valid & EXE_is_load & EXE_rd≠0 & ((ID_rs1_used & ID_rs1==EXE_rd) | (ID_rs2_used & ID_rs2==EXE_rd)).
     - PC, ID hold.
     - EXE loads a bubble.
     - Exactly one bubble per load.
  5. IF_busy:
     - PC holds.
     - ID loads a bubble.
- FSM states:
  - RUN
    - WB_trap with MEM_busy|IF_busy → TRAP_WAIT.
    - WB_trap with neither busy → same cycle: PC_enable=1, redirect_sel=10, ID/EXE/MEM flush, WB loads bubble; stay RUN.
    - Redirect accepted with IF_busy → DROP.
  - DROP (wrong-path fetch in flight)
    - Normal rules apply.
    - In the cycle IF_busy falls: IDreg_flush=1 (returned instruction discarded), → RUN.
    - WB_trap → TRAP_WAIT.
  - TRAP_WAIT
    - PC, ID, EXE, MEM hold; WB loads a bubble.
    - WB_trap, EXE_redirect and load-use are ignored.
    - When MEM_busy=0 & IF_busy=0: PC_enable=1, redirect_sel=10, ID/EXE/MEM/WB flush, → RUN.
- Simultaneous events:
  - WB_trap beats everything, including an EXE_redirect in the same cycle; that redirect is discarded.
- Reset asserted mid-TRAP_WAIT or mid-DROP → RUN immediately, with no pending drop retained.
- Counters (see Optional Feature):
  - loaduse_cnt +1 per load-use bubble cycle.
  - redirect_cnt +1 per accepted EXE redirect.
  - Both saturate at all-ones.

Optional Feature:
YSYX_041461_PIPE_PERF_EN.
- Defined: loaduse_cnt/redirect_cnt count as specified.
- Undefined: counter registers are not built; both ports are tied to 0.

Test Plan:
- Load-use: EXE load with rd=5, ID add with rs1=5 used → one cycle with PC_enable=0, IDreg_enable=0, EXEreg_flush=1; next cycle all enables 1; loaduse_cnt=1.
- Load rd=0, ID rs1=0 → no stall; load rd=5, ID rs2=5 with rs2_used=0 → no stall.
- EXE_redirect with IF_busy=1 for 3 cycles → redirect cycle: redirect_sel=01, ID/EXE flush, state DROP; cycle IF_busy falls: IDreg_flush=1; then RUN; redirect_cnt=1.
- WB_trap while MEM_busy=1 for 4 cycles → 4 cycles of PC/ID/EXE/MEM hold with WB bubble; then one cycle redirect_sel=10 with all four flushes; back to RUN.
- WB_trap and EXE_redirect in the same cycle, nothing busy → redirect_sel=10, redirect_cnt unchanged.
- EXE_busy=1 together with load-use condition → PC/ID/EXE hold, MEMreg_flush=1, EXEreg_flush=0; then rst_n=0 mid-operation → all outputs 0, counters 0.
